// File: rtl/mem_arbiter_if.sv
// Bundle of the request-side and RAM-side signals around the memory arbiter.
// The arbiter uses the slave view; whatever drives requests and models the RAM uses master.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;

  logic        arb_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter: data-first grants with an instruction starvation guard,
// latched RAM request per grant, and a watchdog that aborts a hung access.
module mem_arbiter #(
  parameter int unsigned ISTARVE_MAX = 4,
  parameter int unsigned TIMEOUT     = 64,
  parameter logic [31:0] ABORT_WORD  = 32'hDEADBEEF
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IGRANT = 2'd1;
  localparam logic [1:0] DGRANT = 2'd2;

  localparam int unsigned     WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned     SW      = (ISTARVE_MAX > 0) ? $clog2(ISTARVE_MAX + 1) : 1;
  localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [SW-1:0]   S_MAX   = SW'(ISTARVE_MAX);

  logic [1:0]     state, next_state;
  logic           ram_ren, ram_wen;
  logic [31:0]    ram_addr, ram_store;
  logic [WDW-1:0] wd_cnt;
  logic [SW-1:0]  starve_cnt, starve_sel;
  logic           gone;
  logic           err;

  logic ireq, dreq;
  logic in_grant, done, abort, sel_pt, entry;
  logic i_served, d_served;

  always_comb begin
    ireq     = bus.iREN;
    dreq     = bus.dREN | bus.dWEN;
    in_grant = (state == IGRANT) || (state == DGRANT);
    done     = in_grant && (bus.ram_ready || (wd_cnt == WD_LAST));
    abort    = in_grant && !bus.ram_ready && (wd_cnt == WD_LAST);
    sel_pt   = (state == IDLE) || done;

    // The data grant finishing this cycle already counts toward the starvation limit.
    starve_sel = starve_cnt;
    if ((state == DGRANT) && done && ireq && (starve_cnt != S_MAX))
      starve_sel = starve_cnt + 1'b1;

    next_state = state;
    if (sel_pt) begin
      if (dreq && !(ireq && (starve_sel >= S_MAX)))
        next_state = DGRANT;
      else if (ireq)
        next_state = IGRANT;
      else
        next_state = IDLE;
    end
    entry = sel_pt && (next_state != IDLE);

    // A withdrawn request never gets the result, even if a new request is up now.
    i_served = (state == IGRANT) && done && !gone;
    d_served = (state == DGRANT) && done && !gone;
  end

  assign bus.iwait    = ireq && !i_served;
  assign bus.dwait    = dreq && !d_served;
  assign bus.iload    = i_served ? (abort ? ABORT_WORD : bus.ramload) : '0;
  assign bus.dload    = d_served ? (abort ? ABORT_WORD : (ram_wen ? '0 : bus.ramload)) : '0;
  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.arb_err  = err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ram_ren    <= 1'b0;
      ram_wen    <= 1'b0;
      ram_addr   <= '0;
      ram_store  <= '0;
      wd_cnt     <= '0;
      starve_cnt <= '0;
      gone       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= next_state;

      if (entry) begin
        wd_cnt <= '0;
        gone   <= 1'b0;
        if (next_state == DGRANT) begin
          ram_ren   <= !bus.dWEN;
          ram_wen   <= bus.dWEN;
          ram_addr  <= bus.daddr;
          ram_store <= bus.dstore;
        end else begin
          ram_ren   <= 1'b1;
          ram_wen   <= 1'b0;
          ram_addr  <= bus.iaddr;
          ram_store <= '0;
        end
      end else if (sel_pt) begin
        ram_ren   <= 1'b0;
        ram_wen   <= 1'b0;
        ram_addr  <= '0;
        ram_store <= '0;
        wd_cnt    <= '0;
        gone      <= 1'b0;
      end else if (in_grant) begin
        wd_cnt <= wd_cnt + 1'b1;
        if (((state == IGRANT) && !ireq) || ((state == DGRANT) && !dreq))
          gone <= 1'b1;
      end

      if (!ireq || (entry && (next_state == IGRANT)))
        starve_cnt <= '0;
      else
        starve_cnt <= starve_sel;

      if (abort || (entry && (next_state == DGRANT) && bus.dREN && bus.dWEN))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_mem_arbiter;

  localparam int unsigned ISTARVE_MAX = 4;
  localparam int unsigned TIMEOUT     = 8;
  localparam logic [31:0] ABORT_WORD  = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(
    .ISTARVE_MAX(ISTARVE_MAX),
    .TIMEOUT(TIMEOUT),
    .ABORT_WORD(ABORT_WORD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Bench RAM: answers when the model's grant reaches the chosen latency (0 = never).
  int unsigned ram_lat     = 2;
  logic        ready_force = 1'b0;
  logic [31:0] load_base   = 32'hCAFE0001;
  logic [31:0] rd_count    = '0;

  // Model: owner 0 none, 1 instruction, 2 data.
  int          m_owner  = 0;
  int unsigned m_age    = 0;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_store  = '0;
  logic        m_wr     = 1'b0;
  logic        m_gone   = 1'b0;
  logic        m_err    = 1'b0;
  int unsigned m_starve = 0;

  assign bus.ram_ready = ready_force || ((ram_lat != 0) && (m_owner != 0) && (m_age == ram_lat - 1));
  assign bus.ramload   = load_base + rd_count;

  always @(posedge clk) if (bus.ram_ready) rd_count <= rd_count + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model_step
    logic fin, abrt, dreq, pick;
    int unsigned cnt;
    int nxt;
    if (rst) begin
      m_owner <= 0; m_age <= 0; m_addr <= '0; m_store <= '0;
      m_wr <= 1'b0; m_gone <= 1'b0; m_err <= 1'b0; m_starve <= 0;
    end else begin
      dreq = bus.dREN | bus.dWEN;
      fin  = (m_owner != 0) && (bus.ram_ready || (m_age == TIMEOUT - 1));
      abrt = fin && !bus.ram_ready;
      pick = (m_owner == 0) || fin;
      cnt  = m_starve;
      if ((m_owner == 2) && fin && bus.iREN && (cnt < ISTARVE_MAX)) cnt++;
      nxt = m_owner;
      if (pick) begin
        if (dreq && !(bus.iREN && (cnt >= ISTARVE_MAX))) nxt = 2;
        else if (bus.iREN)                               nxt = 1;
        else                                             nxt = 0;
      end
      m_owner <= nxt;
      if (pick && (nxt != 0)) begin
        m_age   <= 0;
        m_gone  <= 1'b0;
        m_addr  <= (nxt == 2) ? bus.daddr : bus.iaddr;
        m_store <= (nxt == 2) ? bus.dstore : 32'h0;
        m_wr    <= (nxt == 2) && bus.dWEN;
      end else if (nxt == 0) begin
        m_age <= 0; m_gone <= 1'b0; m_addr <= '0; m_store <= '0; m_wr <= 1'b0;
      end else begin
        m_age <= m_age + 1;
        if (((m_owner == 1) && !bus.iREN) || ((m_owner == 2) && !dreq)) m_gone <= 1'b1;
      end
      m_starve <= (!bus.iREN || (pick && (nxt == 1))) ? 0 : cnt;
      if (abrt || (pick && (nxt == 2) && bus.dREN && bus.dWEN)) m_err <= 1'b1;
    end
  end

  always @(negedge clk) begin : compare
    logic grant, fin, abrt, give;
    logic [31:0] e_iload, e_dload;
    grant   = (m_owner != 0);
    fin     = grant && (bus.ram_ready || (m_age == TIMEOUT - 1));
    abrt    = fin && !bus.ram_ready;
    give    = fin && !m_gone;
    e_iload = (give && (m_owner == 1)) ? (abrt ? ABORT_WORD : bus.ramload) : 32'h0;
    e_dload = (give && (m_owner == 2)) ? (abrt ? ABORT_WORD : (m_wr ? 32'h0 : bus.ramload)) : 32'h0;
    chk1 ("m_ramREN",   bus.ramREN,   (m_owner == 1) || ((m_owner == 2) && !m_wr));
    chk1 ("m_ramWEN",   bus.ramWEN,   (m_owner == 2) && m_wr);
    chk32("m_ramaddr",  bus.ramaddr,  grant ? m_addr : 32'h0);
    chk32("m_ramstore", bus.ramstore, grant ? m_store : 32'h0);
    chk1 ("m_iwait",    bus.iwait,    bus.iREN && !(give && (m_owner == 1)));
    chk1 ("m_dwait",    bus.dwait,    (bus.dREN | bus.dWEN) && !(give && (m_owner == 2)));
    chk32("m_iload",    bus.iload,    e_iload);
    chk32("m_dload",    bus.dload,    e_dload);
    chk1 ("m_arb_err",  bus.arb_err,  m_err);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_base(input logic [31:0] first);
    load_base = first - rd_count;
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned n = 0;
    while (!((m_owner == 0) && !bus.iREN && !bus.dREN && !bus.dWEN) && (n < budget)) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL idle_bound: still busy after %0d cycles, required idle", n);
    end
  endtask

  initial begin : stim
    int unsigned writes;
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;

    // Reset with an instruction request pending, then first grant.
    tick(); tick();
    chk1 ("rst_ramREN", bus.ramREN, 1'b0);
    chk1 ("rst_ramWEN", bus.ramWEN, 1'b0);
    chk32("rst_ramaddr", bus.ramaddr, 32'h0);
    chk1 ("rst_iwait", bus.iwait, 1'b1);
    chk1 ("rst_arb_err", bus.arb_err, 1'b0);
    rst = 1'b0;
    set_base(32'hCAFE0001);
    tick();
    chk1 ("first_ramREN", bus.ramREN, 1'b1);
    chk32("first_ramaddr", bus.ramaddr, 32'h40);
    chk1 ("first_iwait", bus.iwait, 1'b1);
    tick();
    chk1 ("first_done_iwait", bus.iwait, 1'b0);
    chk32("first_iload", bus.iload, 32'hCAFE0001);
    tick();
    bus.iREN = 1'b0;
    wait_idle(40);

    // ram_ready while idle starts nothing.
    ready_force = 1'b1;
    tick();
    ready_force = 1'b0;
    #1;
    chk1 ("idle_ready_ramREN", bus.ramREN, 1'b0);

    // Simultaneous requests, latency 3: data first, instruction back-to-back.
    ram_lat = 3;
    set_base(32'hCAFE0001);
    bus.iREN = 1'b1; bus.iaddr = 32'h100;
    bus.dREN = 1'b1; bus.daddr = 32'h200;
    tick();
    chk32("sim_daddr", bus.ramaddr, 32'h200);
    chk1 ("sim_dwait", bus.dwait, 1'b1);
    tick(); tick();
    bus.dREN = 1'b0;
    #1;
    chk32("sim_dload", bus.dload, 32'hCAFE0001);
    chk1 ("sim_iwait_hold", bus.iwait, 1'b1);
    tick();
    chk1 ("sim_b2b_ramREN", bus.ramREN, 1'b1);
    chk32("sim_b2b_iaddr", bus.ramaddr, 32'h100);
    tick(); tick();
    bus.iREN = 1'b0;
    #1;
    chk32("sim_iload", bus.iload, 32'hCAFE0002);
    wait_idle(40);

    // Starvation: instruction held against continuous writes.
    ram_lat = 1;
    bus.iREN = 1'b1; bus.iaddr = 32'h500;
    bus.dWEN = 1'b1; bus.daddr = 32'h600; bus.dstore = 32'h55;
    writes = 0;
    for (int unsigned i = 0; i < 20; i++) begin
      tick();
      if (bus.ramREN) break;
      if (bus.ramWEN && bus.ram_ready) writes++;
    end
    chk32("starve_writes", writes, 32'd4);
    chk32("starve_iaddr", bus.ramaddr, 32'h500);
    bus.iREN = 1'b0; bus.dWEN = 1'b0;
    #1;
    chk32("starve_iload", bus.iload, bus.ramload);
    wait_idle(40);

    // Withdrawal during a data grant, new request on the completion cycle.
    ram_lat = 4;
    set_base(32'hCAFE0001);
    bus.dREN = 1'b1; bus.daddr = 32'h700;
    tick(); tick();
    bus.dREN = 1'b0;
    #1;
    chk1 ("wd_dwait", bus.dwait, 1'b0);
    chk1 ("wd_ramREN_hold", bus.ramREN, 1'b1);
    tick();
    chk1 ("wd_ramREN_hold2", bus.ramREN, 1'b1);
    tick();
    bus.dREN = 1'b1; bus.daddr = 32'h800;
    #1;
    chk32("wd_addr_held", bus.ramaddr, 32'h700);
    chk32("wd_no_forward", bus.dload, 32'h0);
    chk1 ("wd_new_waits", bus.dwait, 1'b1);
    tick();
    chk32("wd_new_addr", bus.ramaddr, 32'h800);
    tick(); tick(); tick();
    chk1 ("wd_new_done", bus.dwait, 1'b0);
    chk32("wd_new_dload", bus.dload, 32'hCAFE0002);
    bus.dREN = 1'b0;
    wait_idle(40);

    // Reset in the middle of an instruction grant.
    ram_lat = 0;
    bus.iREN = 1'b1; bus.iaddr = 32'h900;
    tick();
    chk1 ("mid_ramREN", bus.ramREN, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    chk1 ("mid_rst_ramREN", bus.ramREN, 1'b0);
    chk32("mid_rst_ramaddr", bus.ramaddr, 32'h0);
    chk1 ("mid_rst_iwait", bus.iwait, 1'b1);
    rst = 1'b0; bus.iREN = 1'b0;
    tick();

    // Read and write together: treated as a write, error flagged.
    ram_lat = 2;
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h400; bus.dstore = 32'h1234;
    tick();
    chk1 ("dual_ramWEN", bus.ramWEN, 1'b1);
    chk1 ("dual_ramREN", bus.ramREN, 1'b0);
    chk32("dual_ramstore", bus.ramstore, 32'h1234);
    chk1 ("dual_arb_err", bus.arb_err, 1'b1);
    tick();
    bus.dREN = 1'b0; bus.dWEN = 1'b0;
    wait_idle(40);
    rst = 1'b1;
    tick();
    chk1 ("dual_err_cleared", bus.arb_err, 1'b0);
    rst = 1'b0;

    // Watchdog abort on a read that never completes.
    ram_lat = 0;
    bus.dREN = 1'b1; bus.daddr = 32'h300;
    for (int unsigned i = 0; i < 7; i++) begin
      tick();
      chk1 ("to_dwait", bus.dwait, 1'b1);
    end
    tick();
    chk1 ("to_abort_dwait", bus.dwait, 1'b0);
    chk32("to_abort_dload", bus.dload, 32'hDEADBEEF);
    ram_lat = 1;
    tick();
    bus.dREN = 1'b0;
    #1;
    chk1 ("to_err_set", bus.arb_err, 1'b1);
    wait_idle(40);
    tick(); tick();
    chk1 ("to_err_sticky", bus.arb_err, 1'b1);
    rst = 1'b1;
    tick();
    chk1 ("to_err_reset", bus.arb_err, 1'b0);
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
